dff_bank_reader: RTL

// - Read-side counterpart of the 32-bit enable-loaded register bank.
// - On start, snapshots NUM_REGS registers in one cycle, then streams them out one word per handshake.
// - Output is a valid/ready interface, register 0 first.
// - Sits between the register bank and any serial consumer (debug dump, host readback).

---
 rtl/dff_bank_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dff_bank_reader.sv
// ============================================================================
// Module   : dff_bank_reader
// Brief    : Snapshots NUM_REGS 32-bit registers on start, then streams them
//            out register 0 first over a valid/ready interface.
//            Optional macro DFF_READER_PARITY_EN adds a registered
//            even-parity output aligned with out_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_bank_reader #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = ($clog2(NUM_REGS) > 0) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [32*NUM_REGS-1:0]   bank_q,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
`ifdef DFF_READER_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REGS - 1);
    localparam logic             c_single   = (NUM_REGS == 1);

    state_t                   r_state_q, w_state_d;
    logic [IDX_W-1:0]         r_idx_q, w_idx_d;
    logic [32*NUM_REGS-1:0]   r_snap_q, w_snap_d;
    logic [31:0]              r_data_q, w_data_d;
    logic                     r_valid_q, w_valid_d;
    logic                     r_last_q, w_last_d;
    logic                     r_busy_q, w_busy_d;
    logic                     r_done_q, w_done_d;
    logic [IDX_W-1:0]         w_idx_inc;
    logic [31:0]              w_words [NUM_REGS];

    // Word view of the snapshot so the next word can be picked by index.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_words
        assign w_words[gi] = r_snap_q[32*gi +: 32];
    end

    assign w_idx_inc = r_idx_q + IDX_W'(1);

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_snap_d  = r_snap_q;
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        w_last_d  = r_last_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_snap_d  = bank_q;
                    w_idx_d   = '0;
                    w_data_d  = bank_q[31:0];
                    w_valid_d = 1'b1;
                    w_last_d  = c_single;
                    w_busy_d  = 1'b1;
                    w_state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (r_last_q) begin
                        w_valid_d = 1'b0;
                        w_last_d  = 1'b0;
                        w_done_d  = 1'b1;
                        w_state_d = S_DONE;
                    end else begin
                        w_idx_d  = w_idx_inc;
                        w_data_d = w_words[w_idx_inc];
                        w_last_d = (w_idx_inc == c_last_idx);
                    end
                end
            end
            S_DONE: begin
                w_busy_d  = 1'b0;
                w_state_d = S_IDLE;
            end
            default: begin
                w_valid_d = 1'b0;
                w_last_d  = 1'b0;
                w_busy_d  = 1'b0;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_idx_q   <= '0;
            r_snap_q  <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_snap_q  <= w_snap_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_last_q  <= w_last_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign out_data  = r_data_q;
    assign out_valid = r_valid_q;
    assign out_last  = r_last_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;

`ifdef DFF_READER_PARITY_EN
    logic r_parity_q;
    logic w_parity_d;

    // Parity follows the word that will be registered, keeping it aligned.
    assign w_parity_d = ^w_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_q <= 1'b0;
        end else begin
            r_parity_q <= w_parity_d;
        end
    end

    assign out_parity = r_parity_q;
`endif

endmodule

`default_nettype wire
